// File: rtl/dpa_pkg.sv
// Shared encodings for the DPA image-memory port arbiter.
package dpa_pkg;

    localparam int DEF_AW = 20;
    localparam int DEF_DW = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_P = 2'b01,
        OWN_T = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWNER_P = 1'b0,
        OWNER_T = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/im_port_arbiter_if.sv
// Master-side request/grant signals plus the IM pin bundle of the port arbiter.
interface im_port_arbiter_if import dpa_pkg::*; #(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_last;
    logic          p_gnt;
    logic          p_rvalid;

    logic          t_req;
    logic          t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic          t_last;
    logic          t_gnt;
    logic          t_rvalid;

    logic [DW-1:0] rdata;

    logic [AW-1:0] im_a;
    logic          im_wen_n;
    logic [DW-1:0] im_d;
    logic [DW-1:0] im_q;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, p_last,
        input  t_req, t_we, t_addr, t_wdata, t_last,
        input  im_q,
        output p_gnt, p_rvalid, t_gnt, t_rvalid, rdata,
        output im_a, im_wen_n, im_d
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, p_last,
        output t_req, t_we, t_addr, t_wdata, t_last,
        output im_q,
        input  p_gnt, p_rvalid, t_gnt, t_rvalid, rdata,
        input  im_a, im_wen_n, im_d
    );

endinterface

// File: rtl/im_port_arbiter_rd_tag_pipe.sv
// Carries the read owner alongside the IM read latency and steers returned data.
module im_rd_tag_pipe import dpa_pkg::*; #(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_issue,
    input  owner_t        rd_owner,
    input  logic [DW-1:0] im_q,
    output logic          p_rvalid,
    output logic          t_rvalid,
    output logic [DW-1:0] rdata
);

    rd_tag_t tag_s1;
    rd_tag_t tag_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
            rdata  <= '0;
        end else begin
            tag_s1 <= '{valid: rd_issue, owner: rd_owner};
            tag_s2 <= tag_s1;
            // im_q belongs to the address launched one stage earlier
            if (tag_s1.valid) begin
                rdata <= im_q;
            end
        end
    end

    assign p_rvalid = tag_s2.valid && (tag_s2.owner == OWNER_P);
    assign t_rvalid = tag_s2.valid && (tag_s2.owner == OWNER_T);

endmodule

// File: rtl/im_port_arbiter.sv
// Round-robin burst arbiter sharing the single IM port between photo and time masters.
//   state | meaning
//   IDLE  | no owner; arbitrate this cycle
//   OWN_P | photo master owns the port
//   OWN_T | time master owns the port
module im_port_arbiter import dpa_pkg::*; #(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 16,
    parameter int STALL_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    im_port_arbiter_if.slave   bus
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

    arb_state_t    state_q, state_d;
    owner_t        last_owner_q, last_owner_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [7:0]    stall_cnt_q, stall_cnt_d;
    logic [AW-1:0] im_a_q;
    logic          im_wen_n_q;
    logic [DW-1:0] im_d_q;

    logic          own_req;
    logic          own_we;
    logic          own_last;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          beat;
    owner_t        rd_owner;

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_last  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (state_q)
            OWN_P: begin
                own_req   = bus.p_req;
                own_we    = bus.p_we;
                own_last  = bus.p_last;
                own_addr  = bus.p_addr;
                own_wdata = bus.p_wdata;
            end
            OWN_T: begin
                own_req   = bus.t_req;
                own_we    = bus.t_we;
                own_last  = bus.t_last;
                own_addr  = bus.t_addr;
                own_wdata = bus.t_wdata;
            end
            default: ;
        endcase
    end

    assign beat     = own_req;
    assign rd_owner = (state_q == OWN_T) ? OWNER_T : OWNER_P;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.p_req && (!bus.t_req || (last_owner_q == OWNER_T))) begin
                    state_d      = OWN_P;
                    last_owner_d = OWNER_P;
                    beat_cnt_d   = '0;
                    stall_cnt_d  = '0;
                end else if (bus.t_req) begin
                    state_d      = OWN_T;
                    last_owner_d = OWNER_T;
                    beat_cnt_d   = '0;
                    stall_cnt_d  = '0;
                end
            end
            OWN_P, OWN_T: begin
                // a beat always wins over the stall timeout in the same cycle
                if (beat) begin
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    stall_cnt_d = '0;
                    if (own_last || ((beat_cnt_q + 8'd1) == MAX_BURST_C)) begin
                        state_d = IDLE;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                    if ((stall_cnt_q + 8'd1) == STALL_MAX_C) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_T;
            beat_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            im_a_q       <= '0;
            im_wen_n_q   <= 1'b1;
            im_d_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            if (beat) begin
                im_a_q     <= own_addr;
                im_wen_n_q <= ~own_we;
                im_d_q     <= own_wdata;
            end else begin
                im_wen_n_q <= 1'b1;
            end
        end
    end

    im_rd_tag_pipe #(.DW(DW)) u_rd_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .rd_issue (beat && !own_we),
        .rd_owner (rd_owner),
        .im_q     (bus.im_q),
        .p_rvalid (bus.p_rvalid),
        .t_rvalid (bus.t_rvalid),
        .rdata    (bus.rdata)
    );

    assign bus.p_gnt    = (state_q == OWN_P);
    assign bus.t_gnt    = (state_q == OWN_T);
    assign bus.im_a     = im_a_q;
    assign bus.im_wen_n = im_wen_n_q;
    assign bus.im_d     = im_d_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Self-checking bench for im_port_arbiter: vector table, corner sequences, random traffic vs. model.
module tb_im_port_arbiter;
    import dpa_pkg::*;

    localparam int AW     = 20;
    localparam int DW     = 24;
    localparam int MAXB   = 16;
    localparam int STALLM = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    im_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    im_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .STALL_MAX(STALLM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return {a[3:0], a ^ 20'hA5C3F};
    endfunction

    // memory behaves as a fixed function of the presented address
    assign bus.im_q = pix(bus.im_a);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: owner 0=none 1=photo 2=time; reads queued with their due cycle
    typedef struct {
        int            due;
        bit            is_t;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rdq[$];
    int            m_own;
    bit            m_last_t;
    int            m_beats;
    int            m_idle;
    logic          e_pgnt, e_tgnt, e_wen, e_prv, e_trv;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_rdata;

    task automatic model_step();
        bit            bt, we, last;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        rd_t           r;
        if (reset) begin
            m_own = 0; m_last_t = 1'b1; m_beats = 0; m_idle = 0;
            e_pgnt = 0; e_tgnt = 0; e_wen = 1; e_prv = 0; e_trv = 0;
            e_a = '0; e_d = '0; e_rdata = '0;
            rdq.delete();
            return;
        end
        e_prv = 0; e_trv = 0;
        if (rdq.size() > 0 && rdq[0].due == cyc + 1) begin
            r = rdq.pop_front();
            e_rdata = r.data;
            if (r.is_t) e_trv = 1; else e_prv = 1;
        end
        bt = (m_own == 1 && bus.p_req) || (m_own == 2 && bus.t_req);
        we   = (m_own == 1) ? bus.p_we   : bus.t_we;
        last = (m_own == 1) ? bus.p_last : bus.t_last;
        a    = (m_own == 1) ? bus.p_addr : bus.t_addr;
        wd   = (m_own == 1) ? bus.p_wdata : bus.t_wdata;
        if (bt) begin
            e_a = a; e_wen = ~we; e_d = wd;
            if (!we) rdq.push_back('{cyc + 2, (m_own == 2), pix(a)});
        end else begin
            e_wen = 1;
        end
        if (m_own == 0) begin
            if (bus.p_req && bus.t_req) m_own = m_last_t ? 1 : 2;
            else if (bus.p_req)         m_own = 1;
            else if (bus.t_req)         m_own = 2;
            if (m_own != 0) begin
                m_last_t = (m_own == 2); m_beats = 0; m_idle = 0;
            end
        end else if (bt) begin
            m_beats++; m_idle = 0;
            if (last || m_beats == MAXB) m_own = 0;
        end else begin
            m_idle++;
            if (m_idle == STALLM) m_own = 0;
        end
        e_pgnt = (m_own == 1);
        e_tgnt = (m_own == 2);
    endtask

    task automatic compare_model();
        chk("m_p_gnt",    bus.p_gnt,    e_pgnt);
        chk("m_t_gnt",    bus.t_gnt,    e_tgnt);
        chk("m_im_wen_n", bus.im_wen_n, e_wen);
        chk("m_im_a",     bus.im_a,     e_a);
        chk("m_im_d",     bus.im_d,     e_d);
        chk("m_p_rvalid", bus.p_rvalid, e_prv);
        chk("m_t_rvalid", bus.t_rvalid, e_trv);
        if (e_prv || e_trv) chk("m_rdata", bus.rdata, e_rdata);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input logic pr, input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic pl, input logic tr, input logic tw, input logic [AW-1:0] ta,
                         input logic [DW-1:0] td, input logic tl);
        bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd; bus.p_last = pl;
        bus.t_req = tr; bus.t_we = tw; bus.t_addr = ta; bus.t_wdata = td; bus.t_last = tl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic          p_req, p_last;
        logic [AW-1:0] p_addr;
        logic          x_pgnt, x_wen, x_prv;
        logic [AW-1:0] x_a;
        logic [AW-1:0] x_raddr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int            run, gap, pbeats, tbeats, late, prv_n, trv_n, wen0, hold, handoff;
        int            seq[$];
        logic [AW-1:0] ra;

        tbl[0] = '{1, 0, 20'h00100, 1, 1, 0, 20'h00000, 20'h0};
        tbl[1] = '{1, 0, 20'h00100, 1, 1, 0, 20'h00100, 20'h0};
        tbl[2] = '{1, 0, 20'h00101, 1, 1, 1, 20'h00101, 20'h00100};
        tbl[3] = '{1, 0, 20'h00102, 1, 1, 1, 20'h00102, 20'h00101};
        tbl[4] = '{1, 1, 20'h00103, 0, 1, 1, 20'h00103, 20'h00102};
        tbl[5] = '{0, 0, 20'h00000, 0, 1, 1, 20'h00103, 20'h00103};
        tbl[6] = '{0, 0, 20'h00000, 0, 1, 0, 20'h00103, 20'h0};

        drive(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
        do_reset();
        chk("rst_p_gnt", bus.p_gnt, 0);
        chk("rst_t_gnt", bus.t_gnt, 0);
        chk("rst_wen_n", bus.im_wen_n, 1);
        chk("rst_im_a",  bus.im_a, 0);
        chk("rst_rdata", bus.rdata, 0);

        // photo 4-beat read burst
        foreach (tbl[i]) begin
            drive(tbl[i].p_req, 0, tbl[i].p_addr, '0, tbl[i].p_last, 0, 0, '0, '0, 0);
            step();
            chk("t1_p_gnt",    bus.p_gnt,    tbl[i].x_pgnt);
            chk("t1_wen_n",    bus.im_wen_n, tbl[i].x_wen);
            chk("t1_im_a",     bus.im_a,     tbl[i].x_a);
            chk("t1_p_rvalid", bus.p_rvalid, tbl[i].x_prv);
            if (tbl[i].x_prv) chk("t1_rdata", bus.rdata, pix(tbl[i].x_raddr));
        end

        // continuous contention, bursts capped at MAXB
        do_reset();
        run = 0; gap = 0;
        for (int k = 0; k < 3 * (MAXB + 1); k++) begin
            drive(1, 0, 20'(k), '0, 0, 1, 0, 20'(k + 20'h800), '0, 0);
            step();
            if (bus.p_gnt || bus.t_gnt) begin
                if (run == 0) begin
                    if (seq.size() > 0) chk("rr_gap", gap, 1);
                    seq.push_back(bus.t_gnt ? 2 : 1);
                end
                run++; gap = 0;
            end else begin
                if (run > 0) chk("rr_burst_len", run, MAXB);
                run = 0; gap++;
            end
        end
        chk("rr_grant_count", seq.size(), 3);
        chk("rr_first",  (seq.size() > 0) ? seq[0] : 99, 1);
        chk("rr_second", (seq.size() > 1) ? seq[1] : 99, 2);
        chk("rr_third",  (seq.size() > 2) ? seq[2] : 99, 1);

        // photo reads drain while time writes own the port
        do_reset();
        pbeats = 0; tbeats = 0; late = 0; prv_n = 0; trv_n = 0; wen0 = 0;
        for (int k = 0; k < 16; k++) begin
            drive(pbeats < 4, 0, 20'h00200 + 20'(pbeats), '0, pbeats == 3,
                  tbeats < 4, 1, 20'h00300 + 20'(tbeats), 24'hC0DE00 + 24'(tbeats), tbeats == 3);
            if (bus.p_gnt && pbeats < 4) pbeats++;
            if (bus.t_gnt && tbeats < 4) tbeats++;
            step();
            if (bus.p_rvalid && bus.t_gnt) late++;
            prv_n += int'(bus.p_rvalid);
            trv_n += int'(bus.t_rvalid);
            wen0  += int'(!bus.im_wen_n);
        end
        chk("drain_late_prv", late > 0, 1);
        chk("drain_prv_total", prv_n, 4);
        chk("drain_trv_none", trv_n, 0);
        chk("drain_writes", wen0, 4);

        // forced release after STALLM idle cycles
        do_reset();
        drive(1, 0, 20'h00400, '0, 0, 0, 0, '0, '0, 0);
        step();
        hold = 0; handoff = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, '0, '0, 0, handoff == 0, 1, 20'h00500, 24'h123456, 1);
            step();
            hold += int'(bus.p_gnt);
            if (bus.t_gnt && handoff == 0) handoff = k;
        end
        chk("stall_hold_cycles", hold, STALLM - 1);
        chk("stall_handoff_step", handoff, STALLM + 1);

        // one cycle short of timeout, then a beat restarts the stall count
        do_reset();
        drive(1, 0, 20'h00600, '0, 0, 0, 0, '0, '0, 0);
        step();
        for (int k = 0; k < STALLM - 1; k++) begin
            drive(0, 0, '0, '0, 0, 1, 0, 20'h00700, '0, 0);
            step();
        end
        chk("stall7_kept", bus.p_gnt, 1);
        drive(1, 0, 20'h00601, '0, 0, 1, 0, 20'h00700, '0, 0);
        step();
        for (int k = 0; k < STALLM - 1; k++) begin
            drive(0, 0, '0, '0, 0, 1, 0, 20'h00700, '0, 0);
            step();
        end
        chk("stall_cnt_restart", bus.p_gnt, 1);
        drive(1, 0, 20'h00602, '0, 1, 1, 0, 20'h00700, '0, 0);
        step();
        chk("stall_last_release", bus.p_gnt, 0);

        // reset during beat 3 of a write burst
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 20'h00800 + 20'(k), 24'hAB0000 + 24'(k), 0, 0, 0, '0, '0, 0);
            step();
        end
        reset = 1'b1;
        drive(1, 1, 20'h00803, 24'hAB0003, 0, 1, 0, '0, '0, 0);
        step();
        chk("mrst_p_gnt",  bus.p_gnt, 0);
        chk("mrst_wen_n",  bus.im_wen_n, 1);
        chk("mrst_im_a",   bus.im_a, 0);
        chk("mrst_rvalid", bus.p_rvalid | bus.t_rvalid, 0);
        reset = 1'b0;
        drive(1, 0, 20'h00900, '0, 0, 1, 0, 20'h00A00, '0, 0);
        step();
        chk("mrst_tie_p", bus.p_gnt, 1);
        chk("mrst_tie_t", bus.t_gnt, 0);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            ra = 20'($urandom);
            drive($urandom_range(0, 3) != 0, 1'($urandom), ra, 24'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom), 20'($urandom), 24'($urandom), $urandom_range(0, 5) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
